// File: rtl/wb_write_scheduler.sv
// Arbitrates the single register-file write port among LINK, LOAD and ALU
// writeback requesters, splitting two-result ALU writes over two cycles.
module wb_write_scheduler #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lnk_valid,
  input  logic [DATA_W-1:0] lnk_data,
  output logic              lnk_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              alu_ext,
  input  logic [ADDR_W-1:0] alu_ext_addr,
  input  logic [DATA_W-1:0] alu_ext_data,
  output logic              alu_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              wb_busy
);

  typedef enum logic {IDLE, EXT} state_t;

  localparam logic RR_LOAD = 1'b0;
  localparam logic RR_ALU  = 1'b1;
  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

  state_t            state, state_next;
  logic              rr_ptr, rr_next;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_data;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Grant selection: LINK first, then round-robin between LOAD and ALU
  always_comb begin
    lnk_ready  = 1'b0;
    ld_ready   = 1'b0;
    alu_ready  = 1'b0;
    state_next = state;
    rr_next    = rr_ptr;
    case (state)
      IDLE: begin
        if (lnk_valid) begin
          lnk_ready = 1'b1;
        end else if (ld_valid && (rr_ptr == RR_LOAD || !alu_valid)) begin
          ld_ready = 1'b1;
          rr_next  = RR_ALU;
        end else if (alu_valid) begin
          alu_ready = 1'b1;
          rr_next   = RR_LOAD;
          if (alu_ext) state_next = EXT;
        end
      end
      EXT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = rf_waddr;
    wr_data = rf_wdata;
    if (state == EXT) begin
      wr_en   = 1'b1;
      wr_addr = ext_addr;
      wr_data = ext_data;
    end else if (lnk_ready) begin
      wr_en   = 1'b1;
      wr_addr = LINK_ADDR;
      wr_data = lnk_data;
    end else if (ld_ready) begin
      wr_en   = 1'b1;
      wr_addr = ld_addr;
      wr_data = ld_data;
    end else if (alu_ready) begin
      wr_en   = 1'b1;
      wr_addr = alu_addr;
      wr_data = alu_data;
    end
  end

  // Registered write port; a slot aimed at register 0 is consumed without a strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= RR_LOAD;
      ext_addr <= '0;
      ext_data <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      state  <= state_next;
      rr_ptr <= rr_next;
      rf_we  <= wr_en && (wr_addr != '0);
      if (wr_en) begin
        rf_waddr <= wr_addr;
        rf_wdata <= wr_data;
      end
      if (alu_ready && alu_ext) begin
        ext_addr <= alu_ext_addr;
        ext_data <= alu_ext_data;
      end
    end
  end

  assign wb_busy = (state == EXT);

endmodule

// File: tb/tb_wb_write_scheduler.sv
// Directed bench for wb_write_scheduler: arbitration order, extended writes,
// register-0 suppression and reset during a pending extended write.
module tb_wb_write_scheduler;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              lnk_valid, ld_valid, alu_valid, alu_ext;
  logic [DATA_W-1:0] lnk_data, ld_data, alu_data, alu_ext_data;
  logic [ADDR_W-1:0] ld_addr, alu_addr, alu_ext_addr;
  logic              lnk_ready, ld_ready, alu_ready;
  logic              rf_we, wb_busy;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  int errors = 0;
  int checks = 0;

  wb_write_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINK_REG(31)) dut (
    .clk(clk), .rst_n(rst_n),
    .lnk_valid(lnk_valid), .lnk_data(lnk_data), .lnk_ready(lnk_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .alu_ext(alu_ext), .alu_ext_addr(alu_ext_addr), .alu_ext_data(alu_ext_data),
    .alu_ready(alu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_busy(wb_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rdy(input string tag, input logic l, input logic d, input logic a);
    check({tag, ".lnk_ready"}, 64'(lnk_ready), 64'(l));
    check({tag, ".ld_ready"},  64'(ld_ready),  64'(d));
    check({tag, ".alu_ready"}, 64'(alu_ready), 64'(a));
  endtask

  task automatic check_wr(input string tag, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
    check({tag, ".rf_we"},    64'(rf_we),    64'(we));
    check({tag, ".rf_waddr"}, 64'(rf_waddr), 64'(a));
    check({tag, ".rf_wdata"}, 64'(rf_wdata), 64'(d));
  endtask

  // Advance one clock; returns 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    lnk_valid = 0; ld_valid = 0; alu_valid = 0; alu_ext = 0;
    lnk_data = '0; ld_data = '0; alu_data = '0; alu_ext_data = '0;
    ld_addr = '0; alu_addr = '0; alu_ext_addr = '0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // Idle after reset release
    #1;
    check_wr("reset", 1'b0, 5'd0, 32'h0);
    check_rdy("reset", 1'b0, 1'b0, 1'b0);
    check("reset.wb_busy", 64'(wb_busy), 64'd0);

    // LOAD and ALU together: LOAD first, ALU next
    ld_valid = 1; ld_addr = 5'd5; ld_data = 32'h0000_00AA;
    alu_valid = 1; alu_addr = 5'd6; alu_data = 32'h11;
    #1 check_rdy("rr_c0", 1'b0, 1'b1, 1'b0);
    tick();
    check_wr("rr_w0", 1'b1, 5'd5, 32'hAA);
    #1 check_rdy("rr_c1", 1'b0, 1'b0, 1'b1);
    tick();
    check_wr("rr_w1", 1'b1, 5'd6, 32'h11);
    ld_valid = 0; alu_valid = 0;

    // LINK beats LOAD and ALU; round-robin pointer stays on LOAD
    lnk_valid = 1; lnk_data = 32'h0000_0040;
    ld_valid = 1; ld_addr = 5'd8; ld_data = 32'h88;
    alu_valid = 1; alu_addr = 5'd9; alu_data = 32'h99;
    #1 check_rdy("lnk_c0", 1'b1, 1'b0, 1'b0);
    tick();
    check_wr("lnk_w0", 1'b1, 5'd31, 32'h40);
    lnk_valid = 0;
    #1 check_rdy("lnk_c1", 1'b0, 1'b1, 1'b0);
    tick();
    check_wr("lnk_w1", 1'b1, 5'd8, 32'h88);
    ld_valid = 0;
    #1 check_rdy("lnk_c2", 1'b0, 1'b0, 1'b1);
    tick();
    check_wr("lnk_w2", 1'b1, 5'd9, 32'h99);
    alu_valid = 0;

    // Extended ALU write; a LOAD waiting during EXT must not be granted
    alu_valid = 1; alu_addr = 5'd3; alu_data = 32'hDEAD_BEEF;
    alu_ext = 1; alu_ext_addr = 5'd4; alu_ext_data = 32'h0000_0001;
    #1 check_rdy("ext_c0", 1'b0, 1'b0, 1'b1);
    tick();
    alu_valid = 0; alu_ext = 0;
    ld_valid = 1; ld_addr = 5'd10; ld_data = 32'h10;
    check_wr("ext_w1", 1'b1, 5'd3, 32'hDEAD_BEEF);
    #1 check_rdy("ext_busy", 1'b0, 1'b0, 1'b0);
    check("ext.wb_busy_hi", 64'(wb_busy), 64'd1);
    tick();
    check_wr("ext_w2", 1'b1, 5'd4, 32'h1);
    check("ext.wb_busy_lo", 64'(wb_busy), 64'd0);
    #1 check_rdy("ext_c2", 1'b0, 1'b1, 1'b0);
    tick();
    check_wr("ext_w3", 1'b1, 5'd10, 32'h10);
    ld_valid = 0;

    // Primary to register 0 is suppressed, extended write still lands
    alu_valid = 1; alu_addr = 5'd0; alu_data = 32'h55;
    alu_ext = 1; alu_ext_addr = 5'd7; alu_ext_data = 32'h7;
    #1 check_rdy("r0_c0", 1'b0, 1'b0, 1'b1);
    tick();
    alu_valid = 0; alu_ext = 0;
    check("r0_w1.rf_we", 64'(rf_we), 64'd0);
    check("r0_w1.wb_busy", 64'(wb_busy), 64'd1);
    tick();
    check_wr("r0_w2", 1'b1, 5'd7, 32'h7);
    tick();
    check_wr("idle_hold", 1'b0, 5'd7, 32'h7);

    // Reset during EXT discards the pending extended write
    alu_valid = 1; alu_addr = 5'd12; alu_data = 32'hC;
    alu_ext = 1; alu_ext_addr = 5'd13; alu_ext_data = 32'hD;
    #1 check_rdy("rst_c0", 1'b0, 1'b0, 1'b1);
    tick();
    alu_valid = 0; alu_ext = 0;
    check_wr("rst_w1", 1'b1, 5'd12, 32'hC);
    check("rst.wb_busy_hi", 64'(wb_busy), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check_wr("rst_async", 1'b0, 5'd0, 32'h0);
    check("rst_async.wb_busy", 64'(wb_busy), 64'd0);
    #1 rst_n = 1'b1;
    tick();
    check_wr("rst_post0", 1'b0, 5'd0, 32'h0);
    check("rst_post0.wb_busy", 64'(wb_busy), 64'd0);
    tick();
    check_wr("rst_post1", 1'b0, 5'd0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
